// File: rtl/grf_write_monitor.sv
// grf_write_monitor: records every committed GRF write {PC, A3, WD} in a small
// FIFO and drains each event as three 32-bit beats: PC, {27'b0, A3}, WD.
module grf_write_monitor #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RFWr,
  input  logic [4:0]        A3,
  input  logic [31:0]       WD,
  input  logic [31:0]       PC,
  output logic [31:0]       Out_Word,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Last,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic [15:0]       Drop_Count,
  output logic [1:0]        Dbg_Beat
);

  typedef enum logic [1:0] {
    BEAT_PC = 2'd0,
    BEAT_A3 = 2'd1,
    BEAT_WD = 2'd2
  } beat_e;

  localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // Entry layout: {PC[68:37], A3[36:32], WD[31:0]}
  logic [68:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_drop;
  beat_e             r_beat;
  beat_e             w_beat_nxt;

  logic              w_capture;
  logic              w_handshake;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [68:0]       w_head;

  // Stream handshake: a beat transfers on a rising edge where Out_Valid and
  // Out_Ready are both high; while Out_Valid && !Out_Ready, Out_Word/Out_Last hold.
  assign Empty       = (r_count == '0);
  assign Full        = (r_count == FULL_CNT);
  assign Out_Valid   = !Empty;
  assign Count       = r_count;
  assign Drop_Count  = r_drop;
  assign Dbg_Beat    = r_beat;

  assign w_capture   = RFWr && (A3 != 5'd0);
  assign w_handshake = Out_Valid && Out_Ready;
  assign w_pop       = w_handshake && (r_beat == BEAT_WD);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_push      = w_capture && (!Full || w_pop);
  assign w_drop      = w_capture && Full && !w_pop;
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {PC, A3, WD};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  // Beat sequencer: state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_beat <= BEAT_PC;
    end else begin
      r_beat <= w_beat_nxt;
    end
  end

  // Beat sequencer: next state, advancing only on a handshake
  always_comb begin
    w_beat_nxt = r_beat;
    if (w_handshake) begin
      case (r_beat)
        BEAT_PC: w_beat_nxt = BEAT_A3;
        BEAT_A3: w_beat_nxt = BEAT_WD;
        default: w_beat_nxt = BEAT_PC;
      endcase
    end
  end

  // Beat sequencer: outputs
  always_comb begin
    Out_Word = 32'h0;
    Out_Last = 1'b0;
    if (!Empty) begin
      case (r_beat)
        BEAT_PC: Out_Word = w_head[68:37];
        BEAT_A3: Out_Word = {27'b0, w_head[36:32]};
        default: Out_Word = w_head[31:0];
      endcase
      Out_Last = (r_beat == BEAT_WD);
    end
  end

endmodule
